// File: rtl/sad_defs.sv
// -----------------------------------------------------------------------------
// sad_defs: shared definitions for the SAD datapath front end.
//   PIX_W        - pixel width (unsigned samples)
//   SUM_W        - running-sum / SAD width
//   sad_state_e  - control FSM encoding shared with any future parallel-lane SAD
// -----------------------------------------------------------------------------
package sad_defs;

  localparam int PIX_W = 8;
  localparam int SUM_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sad_state_e;

endpackage : sad_defs

// File: rtl/sad_absdiff.sv
// -----------------------------------------------------------------------------
// sad_absdiff: combinational unsigned absolute difference |a - b|.
// The larger operand is always the minuend, so the result never wraps.
//   a, b  in  [PIX_W-1:0]  unsigned pixels
//   diff  out [PIX_W-1:0]  |a - b|
// -----------------------------------------------------------------------------
module sad_absdiff
  import sad_defs::*;
(
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] diff
);

  always_comb begin
    diff = (a >= b) ? (a - b) : (b - a);
  end

endmodule : sad_absdiff

// File: rtl/sad_accumulator.sv
// -----------------------------------------------------------------------------
// sad_accumulator: sequential front end of the SAD datapath.
//
// Accepts BLOCK_PIXELS pixel pairs over valid/ready, registers |a-b| (stage 1),
// feeds it with the running sum to the external combinational adder, and
// captures the adder result back into the sum register (stage 2). When the
// block is complete the final SAD is published on sad with a one-cycle
// sad_valid strobe.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   start      in   begin a new block; honoured only in IDLE
//   pix_a      in   [7:0]  current-block pixel
//   pix_b      in   [7:0]  reference-block pixel
//   in_valid   in   pix_a/pix_b valid
//   in_ready   out  a pair is accepted this cycle when in_valid is also high
//   abs_out    out  [7:0]  registered |pix_a-pix_b|, to the adder
//   sum_out    out  [31:0] running-sum register, to the adder
//   adder_in   in   [31:0] adder result (abs_out + sum_out)
//   busy       out  high in ACCUM and DRAIN
//   sad_valid  out  one-cycle strobe, sad is final
//   sad        out  [31:0] last completed SAD, held until the next completion
//   sad_ovf    out  (SAD_SAT_EN only) block saturated; valid with sad
//
// Build option: define SAD_SAT_EN to saturate the running sum at 32'hFFFF_FFFF
// instead of wrapping, and to expose sad_ovf.
// -----------------------------------------------------------------------------
module sad_accumulator
  import sad_defs::*;
#(
  parameter int BLOCK_PIXELS = 256,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W-1:0] pix_a,
  input  logic [PIX_W-1:0] pix_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] abs_out,
  output logic [SUM_W-1:0] sum_out,
  input  logic [SUM_W-1:0] adder_in,
  output logic             busy,
  output logic             sad_valid,
  output logic [SUM_W-1:0] sad
`ifdef SAD_SAT_EN
  ,
  output logic             sad_ovf
`endif
);

  // Elaboration-time parameter sanity.
  if (BLOCK_PIXELS < 1 || BLOCK_PIXELS > 65535) begin : g_bad_block
    $error("sad_accumulator: BLOCK_PIXELS must be in 1..65535");
  end
  if ((64'd1 << CNT_W) <= 64'(BLOCK_PIXELS)) begin : g_bad_cnt_w
    $error("sad_accumulator: 2**CNT_W must exceed BLOCK_PIXELS");
  end

  // count_q holds the number of pairs already accepted, so the final pair is
  // the one that arrives while count_q equals BLOCK_PIXELS-1.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_PIXELS - 1);

  sad_state_e       state_q,     state_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [PIX_W-1:0] abs_q,       abs_d;
  logic             abs_v_q,     abs_v_d;
  logic [SUM_W-1:0] sum_q,       sum_d;
  logic [SUM_W-1:0] sad_q,       sad_d;
  logic             sad_valid_q, sad_valid_d;
  logic             in_ready_q,  in_ready_d;
  logic             busy_q,      busy_d;
`ifdef SAD_SAT_EN
  logic             ovf_q,       ovf_d;
  logic             sad_ovf_q,   sad_ovf_d;
`endif

  logic             accept;
  logic [PIX_W-1:0] abs_now;

  sad_absdiff u_absdiff (
    .a    (pix_a),
    .b    (pix_b),
    .diff (abs_now)
  );

  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d     = state_q;
    count_d     = count_q;
    abs_d       = abs_q;
    abs_v_d     = 1'b0;
    sum_d       = sum_q;
    sad_d       = sad_q;
    sad_valid_d = 1'b0;
`ifdef SAD_SAT_EN
    ovf_d       = ovf_q;
    sad_ovf_d   = sad_ovf_q;
`endif

    // in_ready_q is high exactly in ACCUM, so it doubles as the accept gate.
    accept = in_ready_q && in_valid;

    // Stage 1: register the absolute difference; abs_out holds otherwise.
    if (accept) begin
      abs_d   = abs_now;
      abs_v_d = 1'b1;
      count_d = count_q + 1'b1;
    end

    // Stage 2: the adder result is taken only behind a fresh abs, so a stale
    // abs_out is never accumulated twice.
    if (abs_v_q) begin
`ifdef SAD_SAT_EN
      // An unsigned add that wraps yields a result below the old sum. Once
      // saturated, any non-zero abs wraps again and zero abs leaves all-ones,
      // so the sum stays pinned for the rest of the block.
      if (adder_in < sum_q) begin
        sum_d = '1;
        ovf_d = 1'b1;
      end else begin
        sum_d = adder_in;
      end
`else
      sum_d = adder_in;
`endif
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          sum_d   = '0;
          count_d = '0;
          abs_v_d = 1'b0;
`ifdef SAD_SAT_EN
          ovf_d     = 1'b0;
          sad_ovf_d = 1'b0;
`endif
        end
      end
      S_ACCUM: begin
        if (accept && (count_q == LAST_IDX)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // First DRAIN cycle still has the final abs in flight; once abs_v_q
        // drops the sum is final. The result is loaded on entry to DONE so
        // sad and sad_valid are presented together during DONE.
        if (!abs_v_q) begin
          state_d     = S_DONE;
          sad_d       = sum_q;
          sad_valid_d = 1'b1;
`ifdef SAD_SAT_EN
          sad_ovf_d   = ovf_q;
`endif
        end
      end
      S_DONE: begin
        // start is deliberately not examined here; it is not queued.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake/status outputs are decoded from the next state and registered.
    in_ready_d = (state_d == S_ACCUM);
    busy_d     = (state_d == S_ACCUM) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      abs_q       <= '0;
      abs_v_q     <= 1'b0;
      sum_q       <= '0;
      sad_q       <= '0;
      sad_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SAD_SAT_EN
      ovf_q       <= 1'b0;
      sad_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      abs_q       <= abs_d;
      abs_v_q     <= abs_v_d;
      sum_q       <= sum_d;
      sad_q       <= sad_d;
      sad_valid_q <= sad_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef SAD_SAT_EN
      ovf_q       <= ovf_d;
      sad_ovf_q   <= sad_ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign abs_out   = abs_q;
  assign sum_out   = sum_q;
  assign busy      = busy_q;
  assign sad_valid = sad_valid_q;
  assign sad       = sad_q;
`ifdef SAD_SAT_EN
  assign sad_ovf   = sad_ovf_q;
`endif

endmodule : sad_accumulator

// File: tb/tb_sad_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sad_accumulator: directed, table-driven bench for sad_accumulator.
// Three instances (BLOCK_PIXELS = 4, 256, 1) share clk/rst/pixel inputs and
// have private start strobes; each has a bench adder model. Inputs change and
// outputs are sampled on the falling edge. Cycle 1 is the cycle right after
// the edge that accepted start.
// Define SAD_SAT_EN to include the saturation sequence.
// -----------------------------------------------------------------------------
module tb_sad_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pix_a, pix_b;
  logic       in_valid;

  always #5 clk = ~clk;

  // ---- instance with BLOCK_PIXELS = 4 ----
  logic        start4, rdy4, busy4, sv4;
  logic [7:0]  abs4;
  logic [31:0] sum4, adder4, sad4;
`ifdef SAD_SAT_EN
  logic        ovf4;
  logic        force_pre;
  assign adder4 = force_pre ? 32'hFFFF_FFF0 : ({24'd0, abs4} + sum4);
`else
  assign adder4 = {24'd0, abs4} + sum4;
`endif

  sad_accumulator #(.BLOCK_PIXELS(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .pix_a(pix_a), .pix_b(pix_b),
    .in_valid(in_valid), .in_ready(rdy4), .abs_out(abs4), .sum_out(sum4),
    .adder_in(adder4), .busy(busy4), .sad_valid(sv4), .sad(sad4)
`ifdef SAD_SAT_EN
    , .sad_ovf(ovf4)
`endif
  );

  // ---- instance with BLOCK_PIXELS = 256 ----
  logic        start256, rdy256, busy256, sv256;
  logic [7:0]  abs256;
  logic [31:0] sum256, adder256, sad256;
`ifdef SAD_SAT_EN
  logic        ovf256;
`endif
  assign adder256 = {24'd0, abs256} + sum256;

  sad_accumulator #(.BLOCK_PIXELS(256), .CNT_W(16)) dut256 (
    .clk(clk), .rst(rst), .start(start256), .pix_a(pix_a), .pix_b(pix_b),
    .in_valid(in_valid), .in_ready(rdy256), .abs_out(abs256), .sum_out(sum256),
    .adder_in(adder256), .busy(busy256), .sad_valid(sv256), .sad(sad256)
`ifdef SAD_SAT_EN
    , .sad_ovf(ovf256)
`endif
  );

  // ---- instance with BLOCK_PIXELS = 1 ----
  logic        start1, rdy1, busy1, sv1;
  logic [7:0]  abs1;
  logic [31:0] sum1, adder1, sad1;
`ifdef SAD_SAT_EN
  logic        ovf1;
`endif
  assign adder1 = {24'd0, abs1} + sum1;

  sad_accumulator #(.BLOCK_PIXELS(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pix_a(pix_a), .pix_b(pix_b),
    .in_valid(in_valid), .in_ready(rdy1), .abs_out(abs1), .sum_out(sum1),
    .adder_in(adder1), .busy(busy1), .sad_valid(sv1), .sad(sad1)
`ifdef SAD_SAT_EN
    , .sad_ovf(ovf1)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] exp_sum;  // running sum once this pair has been added
  } vec_t;

  vec_t vec[4];

  // One 4-pair block on dut4. gap_len idle cycles are inserted before pair
  // gap_at; poke pulses start in ACCUM (cycle 2) and in DONE.
  task automatic run4(input int gap_at, input int gap_len, input bit poke,
                      input logic [31:0] exp_sad);
    int slots[$];
    int cf, s, p_idx, exp_cnt;
    logic [31:0] e_sum;
    for (int i = 0; i < 4; i++) begin
      if (i == gap_at) for (int g = 0; g < gap_len; g++) slots.push_back(-1);
      slots.push_back(i);
    end
    cf = slots.size();  // cycle in which the final pair is presented
    @(negedge clk); start4 = 1'b1; in_valid = 1'b0;
    @(negedge clk); start4 = 1'b0;
    e_sum = 32'd0; p_idx = -1; exp_cnt = 0;
    for (int c = 1; c <= cf + 4; c++) begin
      check("in_ready", {31'd0, rdy4}, {31'd0, c <= cf});
      check("busy", {31'd0, busy4}, {31'd0, c <= cf + 2});
      check("sad_valid", {31'd0, sv4}, {31'd0, c == cf + 3});
      check("sum_out", sum4, e_sum);
      check("count", {16'd0, dut4.count_q}, exp_cnt);
      if (c == cf + 3) check("sad", sad4, exp_sad);
      s = (c <= cf) ? slots[c-1] : -1;
      in_valid = (s >= 0);
      if (s >= 0) begin pix_a = vec[s].a; pix_b = vec[s].b; end
      else begin pix_a = 8'hFF; pix_b = 8'h00; end  // garbage while stalled
      start4 = poke && (c == 2 || c == cf + 3);
      if (p_idx >= 0) e_sum = vec[p_idx].exp_sum;
      p_idx = s;
      if (s >= 0) exp_cnt++;
      @(negedge clk);
    end
    start4 = 1'b0; in_valid = 1'b0;
    check("idle_ready", {31'd0, rdy4}, 32'd0);
    check("idle_busy", {31'd0, busy4}, 32'd0);
    check("idle_sad_valid", {31'd0, sv4}, 32'd0);
    check("sad_held", sad4, exp_sad);
  endtask

  // One 256-pair back-to-back block on dut256 with constant pixels.
  task automatic run256(input logic [7:0] a, input logic [7:0] b, input logic [31:0] exp_sad);
    int seen;
    seen = 0;
    @(negedge clk); start256 = 1'b1; in_valid = 1'b0;
    @(negedge clk); start256 = 1'b0;
    check("sum256_cleared", sum256, 32'd0);
    for (int c = 1; c <= 280; c++) begin
      if (sv256 && seen == 0) begin
        seen = c;
        check("sad256", sad256, exp_sad);
      end
      in_valid = (c <= 256); pix_a = a; pix_b = b;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("sad256_cycle", seen, 32'd259);
  endtask

  initial begin
    vec[0] = '{a: 8'd10,  b: 8'd3,   exp_sum: 32'd7};
    vec[1] = '{a: 8'd3,   b: 8'd10,  exp_sum: 32'd14};
    vec[2] = '{a: 8'd0,   b: 8'd255, exp_sum: 32'd269};
    vec[3] = '{a: 8'd200, b: 8'd200, exp_sum: 32'd269};

    rst = 1'b1; start4 = 1'b0; start256 = 1'b0; start1 = 1'b0;
    in_valid = 1'b0; pix_a = 8'd0; pix_b = 8'd0;
`ifdef SAD_SAT_EN
    force_pre = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, rdy4}, 32'd0);
    check("rst_busy", {31'd0, busy4}, 32'd0);
    check("rst_sad_valid", {31'd0, sv4}, 32'd0);
    check("rst_sum", sum4, 32'd0);
    check("rst_abs", {24'd0, abs4}, 32'd0);
    check("rst_sad", sad4, 32'd0);
    rst = 1'b0;

    // Back-to-back, stalled, and start-poked blocks.
    run4(-1, 0, 1'b0, 32'd269);
    run4(2, 3, 1'b0, 32'd269);
    run4(-1, 0, 1'b1, 32'd269);

    // Reset after two accepted pairs aborts the block.
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    in_valid = 1'b1; pix_a = vec[0].a; pix_b = vec[0].b;
    @(negedge clk); pix_a = vec[1].a; pix_b = vec[1].b;
    @(negedge clk); pix_a = vec[2].a; pix_b = vec[2].b; rst = 1'b1;
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    check("abort_ready", {31'd0, rdy4}, 32'd0);
    check("abort_busy", {31'd0, busy4}, 32'd0);
    check("abort_sum", sum4, 32'd0);
    check("abort_abs", {24'd0, abs4}, 32'd0);
    check("abort_sad", sad4, 32'd0);
    for (int c = 0; c < 6; c++) begin
      check("abort_no_strobe", {31'd0, sv4}, 32'd0);
      @(negedge clk);
    end
    run4(-1, 0, 1'b0, 32'd269);

    // BLOCK_PIXELS = 1: a single accept ends ACCUM.
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check("bp1_ready", {31'd0, rdy1}, {31'd0, c == 1});
      check("bp1_sad_valid", {31'd0, sv1}, {31'd0, c == 4});
      if (c == 4) check("bp1_sad", sad1, 32'd7);
      in_valid = (c == 1); pix_a = 8'd9; pix_b = 8'd2;
      @(negedge clk);
    end
    in_valid = 1'b0;

    // Full-size blocks: maximum per-pair difference, then all-equal pixels.
    run256(8'd255, 8'd0, 32'd65280);
    run256(8'd5, 8'd5, 32'd0);

`ifdef SAD_SAT_EN
    // Adder model forces FFFF_FFF0 for the first sum, then 0x20 overflows it.
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) check("sat_ovf_clear", {31'd0, ovf4}, 32'd0);
      if (c == 3) check("sat_preload", sum4, 32'hFFFF_FFF0);
      if (c >= 4) check("sat_sum", sum4, 32'hFFFF_FFFF);
      check("sat_sad_valid", {31'd0, sv4}, {31'd0, c == 7});
      if (c == 7) begin
        check("sat_sad", sad4, 32'hFFFF_FFFF);
        check("sat_ovf", {31'd0, ovf4}, 32'd1);
      end
      in_valid  = (c <= 4);
      pix_a     = (c == 2) ? 8'h20 : 8'h00;
      pix_b     = 8'h00;
      force_pre = (c <= 2);
      @(negedge clk);
    end
    in_valid = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sad_accumulator
